dht11_uart_reporter: RTL and testbench

Downstream consumer of the DHT11 controller unit's 40-bit frame. On each completed sensor read, it checks the checksum and formats humidity and temperature as an ASCII line. It then streams the line byte by byte into the existing UART transmitter through a start/busy handshake. It runs alongside the FND display path and shares the same frame bus, clock and reset.

---
 rtl/dht11_uart_reporter.sv | 133 +++++++++++++
 tb/tb_dht11_uart_reporter.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dht11_uart_reporter.sv
// DHT11 frame to ASCII line reporter.
// Takes a completed 40-bit sensor frame and verifies its checksum. It then
// formats either "H:hhh.d T:ttt.d\r\n" or "ERR\r\n" and streams the line
// into a UART transmitter through a start/busy handshake.
module dht11_uart_reporter (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_valid,
  input  logic [39:0] frame,
  input  logic        tx_busy,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  output logic        busy,
  output logic        csum_err,
  output logic [7:0]  drop_cnt
);

  typedef enum logic [2:0] {IDLE, CHECK, SEND, WAIT_HI, WAIT_LO} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [39:0] frame_q;
  logic [7:0]  msg [17];
  logic [4:0]  idx;
  logic [4:0]  len;
  logic [7:0]  tx_data_q;
  logic [7:0]  sum;
  logic        sum_ok;

  // Decimal digit split of an 8-bit value, as ASCII characters.
  function automatic logic [7:0] hund_char(input logic [7:0] v);
    return 8'h30 + v / 8'd100;
  endfunction

  function automatic logic [7:0] tens_char(input logic [7:0] v);
    return 8'h30 + (v / 8'd10) % 8'd10;
  endfunction

  function automatic logic [7:0] unit_char(input logic [7:0] v);
    return 8'h30 + v % 8'd10;
  endfunction

  // Fractional byte shown as one digit; anything above 9 is clamped.
  function automatic logic [7:0] frac_char(input logic [7:0] v);
    return (v > 8'd9) ? 8'h39 : 8'h30 + v;
  endfunction

  assign sum    = frame_q[39:32] + frame_q[31:24] + frame_q[23:16] + frame_q[15:8];
  assign sum_ok = (sum == frame_q[7:0]);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic for the byte-streaming handshake.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (frame_valid) state_nxt = CHECK;
      CHECK:   state_nxt = SEND;
      SEND:    if (!tx_busy) state_nxt = WAIT_HI;
      WAIT_HI: if (tx_busy) state_nxt = WAIT_LO;
      WAIT_LO: if (!tx_busy) state_nxt = (idx == len - 5'd1) ? IDLE : SEND;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state; tx_data only changes on a start pulse.
  always_comb begin
    tx_start = (state == SEND) && !tx_busy;
    csum_err = (state == CHECK) && !sum_ok;
    busy     = (state != IDLE);
    tx_data  = tx_start ? msg[idx] : tx_data_q;
  end

  // Frame latch and message buffer load; frozen for the whole transmission.
  always_ff @(posedge clk) begin
    if (state == IDLE && frame_valid) frame_q <= frame;
    if (state == CHECK) begin
      if (sum_ok) begin
        msg[0]  <= 8'h48;
        msg[1]  <= 8'h3A;
        msg[2]  <= hund_char(frame_q[39:32]);
        msg[3]  <= tens_char(frame_q[39:32]);
        msg[4]  <= unit_char(frame_q[39:32]);
        msg[5]  <= 8'h2E;
        msg[6]  <= frac_char(frame_q[31:24]);
        msg[7]  <= 8'h20;
        msg[8]  <= 8'h54;
        msg[9]  <= 8'h3A;
        msg[10] <= hund_char(frame_q[23:16]);
        msg[11] <= tens_char(frame_q[23:16]);
        msg[12] <= unit_char(frame_q[23:16]);
        msg[13] <= 8'h2E;
        msg[14] <= frac_char(frame_q[15:8]);
        msg[15] <= 8'h0D;
        msg[16] <= 8'h0A;
      end else begin
        msg[0]  <= 8'h45;
        msg[1]  <= 8'h52;
        msg[2]  <= 8'h52;
        msg[3]  <= 8'h0D;
        msg[4]  <= 8'h0A;
      end
    end
  end

  // Byte index, message length and last transmitted byte.
  always_ff @(posedge clk) begin
    if (!rst) begin
      idx       <= 5'd0;
      len       <= 5'd0;
      tx_data_q <= 8'h00;
    end else begin
      if (state == CHECK) begin
        idx <= 5'd0;
        len <= sum_ok ? 5'd17 : 5'd5;
      end else if (state == WAIT_LO && !tx_busy && idx != len - 5'd1) begin
        idx <= idx + 5'd1;
      end
      if (tx_start) tx_data_q <= msg[idx];
    end
  end

  // Saturating count of frames that arrived while a message was in flight.
  always_ff @(posedge clk) begin
    if (!rst)                                              drop_cnt <= 8'd0;
    else if (frame_valid && state != IDLE && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
  end

endmodule

// File: tb/tb_dht11_uart_reporter.sv
// Bench for dht11_uart_reporter: directed scenarios plus randomized traffic,
// checked every cycle against a message-level reference model.
module tb_dht11_uart_reporter;

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        frame_valid = 1'b0;
  logic [39:0] frame = 40'd0;
  logic        tx_busy = 1'b0;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        busy;
  logic        csum_err;
  logic [7:0]  drop_cnt;

  dht11_uart_reporter dut (
    .clk(clk), .rst(rst), .frame_valid(frame_valid), .frame(frame),
    .tx_busy(tx_busy), .tx_start(tx_start), .tx_data(tx_data),
    .busy(busy), .csum_err(csum_err), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  // reference model state
  bit   chk_en = 0;
  bit   m_active = 0;
  bit   m_check = 0;
  bit   m_bad = 0;
  int   m_phase = 0;      // 0 may send, 1 await busy rise, 2 await busy fall
  int   m_drop = 0;
  logic [7:0] m_last = 8'h00;
  bq_t  q;
  bit   a_idle;
  bq_t  a_msg;
  bit   a_bad;
  bit   exp_start;

  // UART responder and observation state
  int   busy_len = 10;
  int   uart_cnt = 0;
  bit   uart_pend = 0;
  int   stall_cnt = 0;
  bit   stall_hi = 0;
  bit   stall_prev = 0;
  int   stall_end_cyc = -1;
  int   first_tx_cyc = -1;
  int   last_start_cyc = -100;
  int   sent_cnt = 0;
  int   err_seen = 0;
  int   err_cyc = -1;
  int   fv_cyc = 0;
  string cap = "";
  string crlf;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic string esc(input string s);
    string r = "";
    for (int i = 0; i < s.len(); i++)
      r = {r, (s[i] < 8'd32) ? "~" : $sformatf("%c", s[i])};
    return r;
  endfunction

  task automatic chk_str(input string nm, input string act, input string exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got \"%s\", expected \"%s\"", nm, esc(act), esc(exp));
    end
  endtask

  // Message the block must emit for a frame, from plain decimal arithmetic.
  function automatic void build_msg(input logic [39:0] f, output bq_t m, output bit bad);
    int rh, rd, th, td;
    rh = int'(f[39:32]); rd = int'(f[31:24]); th = int'(f[23:16]); td = int'(f[15:8]);
    bad = (((rh + rd + th + td) % 256) != int'(f[7:0]));
    m = {};
    if (bad) begin
      m.push_back(8'h45); m.push_back(8'h52); m.push_back(8'h52);
      m.push_back(8'h0D); m.push_back(8'h0A);
    end else begin
      m.push_back(8'h48); m.push_back(8'h3A);
      m.push_back(8'(48 + rh / 100)); m.push_back(8'(48 + (rh / 10) % 10)); m.push_back(8'(48 + rh % 10));
      m.push_back(8'h2E); m.push_back(8'(48 + ((rd > 9) ? 9 : rd)));
      m.push_back(8'h20); m.push_back(8'h54); m.push_back(8'h3A);
      m.push_back(8'(48 + th / 100)); m.push_back(8'(48 + (th / 10) % 10)); m.push_back(8'(48 + th % 10));
      m.push_back(8'h2E); m.push_back(8'(48 + ((td > 9) ? 9 : td)));
      m.push_back(8'h0D); m.push_back(8'h0A);
    end
  endfunction

  function automatic string to_str(input bq_t m);
    string s = "";
    foreach (m[i]) s = {s, $sformatf("%c", m[i])};
    return s;
  endfunction

  // Model advance at each active edge, from the inputs the DUT samples.
  always @(posedge clk) begin
    if (!rst) begin
      chk_en = 1; m_active = 0; m_check = 0; m_bad = 0; m_phase = 0;
      m_drop = 0; m_last = 8'h00; q.delete();
    end else if (chk_en) begin
      a_idle = !m_active;
      if (m_active) begin
        if (m_check) m_check = 0;
        else if (m_phase == 1) begin
          if (tx_busy) m_phase = 2;
        end else if (m_phase == 2 && !tx_busy) begin
          if (q.size() == 0) m_active = 0;
          else m_phase = 0;
        end
      end
      if (frame_valid) begin
        if (a_idle) begin
          build_msg(frame, a_msg, a_bad);
          q = a_msg; m_bad = a_bad; m_active = 1; m_check = 1; m_phase = 0;
        end else if (m_drop < 255) m_drop++;
      end
    end
  end

  // UART responder plus per-cycle comparison against the model.
  always @(negedge clk) begin
    cyc++;
    if (uart_pend) begin uart_cnt = busy_len; uart_pend = 0; end
    else if (uart_cnt > 0) uart_cnt--;
    stall_hi = (stall_cnt > 0);
    if (stall_hi) stall_cnt--;
    if (stall_prev && !stall_hi) stall_end_cyc = cyc;
    stall_prev = stall_hi;
    tx_busy = (uart_cnt > 0) || stall_hi;
    #1;
    if (tx_start) uart_pend = 1;
    if (chk_en) begin
      exp_start = m_active && !m_check && m_phase == 0 && !tx_busy && q.size() > 0;
      chk("tx_start", int'(tx_start), int'(exp_start));
      if (exp_start) begin
        chk("tx_data", int'(tx_data), int'(q[0]));
        m_last = q.pop_front();
        m_phase = 1;
      end else begin
        chk("tx_data_hold", int'(tx_data), int'(m_last));
      end
      chk("busy", int'(busy), int'(m_active));
      chk("csum_err", int'(csum_err), int'(m_check && m_bad));
      chk("drop_cnt", int'(drop_cnt), m_drop);
    end
    if (tx_start) begin
      chk("start_gap_ok", int'((cyc - last_start_cyc) >= 3), 1);
      last_start_cyc = cyc;
      cap = {cap, $sformatf("%c", tx_data)};
      sent_cnt++;
      if (first_tx_cyc < 0) first_tx_cyc = cyc;
    end
    if (csum_err) begin err_seen++; err_cyc = cyc; end
  end

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic clear_obs();
    cap = ""; sent_cnt = 0; err_seen = 0; err_cyc = -1; first_tx_cyc = -1;
  endtask

  task automatic send_frame(input logic [39:0] f);
    tick();
    frame = f; frame_valid = 1'b1; fv_cyc = cyc;
    tick();
    frame_valid = 1'b0;
    frame = {$urandom(), 8'($urandom())};
  endtask

  task automatic wait_done(input int max);
    int n = 0;
    while ((busy || tx_busy || m_active) && n < max) begin tick(); n++; end
    if (n >= max) begin
      n_vec++; n_err++;
      $display("FAIL wait_done: still busy after %0d cycles", max);
    end
    tick();
  endtask

  function automatic logic [39:0] rand_frame();
    logic [7:0] b0, b1, b2, b3, cs;
    b0 = 8'($urandom()); b1 = 8'($urandom_range(12, 0));
    b2 = 8'($urandom()); b3 = 8'($urandom_range(12, 0));
    cs = b0 + b1 + b2 + b3;
    if ($urandom_range(1, 0) == 0) cs = cs ^ 8'($urandom_range(255, 1));
    return {b0, b1, b2, b3, cs};
  endfunction

  string s_ok1, s_ok3, s_err;

  initial begin
    bq_t tm;
    bit  tb;
    int  n;
    crlf  = $sformatf("%c%c", 8'd13, 8'd10);
    s_ok1 = {"H:045.0 T:023.5", crlf};
    s_ok3 = {"H:255.9 T:200.3", crlf};
    s_err = {"ERR", crlf};

    // model pinned to hand-computed lines
    build_msg(40'h2D_00_17_05_49, tm, tb);
    chk_str("model_ok1", to_str(tm), s_ok1);
    build_msg(40'hFF_0C_C8_03_D6, tm, tb);
    chk_str("model_wrap", to_str(tm), s_ok3);
    build_msg(40'h2D_00_17_05_48, tm, tb);
    chk_str("model_err", to_str(tm), s_err);

    // reset state
    repeat (3) tick();
    chk("rst_busy", int'(busy), 0);
    chk("rst_tx_start", int'(tx_start), 0);
    chk("rst_tx_data", int'(tx_data), 0);
    chk("rst_drop", int'(drop_cnt), 0);
    chk("rst_csum", int'(csum_err), 0);
    rst = 1'b1;
    tick();

    // valid frame
    clear_obs(); busy_len = 10;
    send_frame(40'h2D_00_17_05_49);
    wait_done(1000);
    chk_str("ok_line", cap, s_ok1);
    chk("ok_first_start", first_tx_cyc, fv_cyc + 2);
    chk("ok_no_csum_err", err_seen, 0);

    // checksum error
    clear_obs();
    send_frame(40'h2D_00_17_05_48);
    wait_done(1000);
    chk_str("err_line", cap, s_err);
    chk("err_pulses", err_seen, 1);
    chk("err_cycle", err_cyc, fv_cyc + 1);

    // wrap-around and clamping
    clear_obs();
    send_frame(40'hFF_0C_C8_03_D6);
    wait_done(1000);
    chk_str("wrap_line", cap, s_ok3);

    // drop counting with a slow UART
    clear_obs(); busy_len = 30;
    send_frame(40'h2D_00_17_05_49);
    repeat (20) tick();
    for (int i = 0; i < 3; i++) begin
      frame_valid = 1'b1; tick(); frame_valid = 1'b0; tick();
    end
    chk("drop_three", int'(drop_cnt), 3);
    frame_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin frame = {$urandom(), 8'($urandom())}; tick(); end
    frame_valid = 1'b0;
    tick();
    chk("drop_sat", int'(drop_cnt), 255);
    wait_done(3000);
    chk_str("drop_line", cap, s_ok1);

    // handshake stall on entry to SEND
    clear_obs(); busy_len = 10;
    tick();
    stall_cnt = 50;
    send_frame(40'h2D_00_17_05_49);
    wait_done(1500);
    chk("stall_first_start", first_tx_cyc, stall_end_cyc);
    chk("stall_first_byte", int'(cap.len() > 0 ? cap[0] : 8'h00), 8'h48);
    chk_str("stall_line", cap, s_ok1);

    // reset mid-message
    clear_obs();
    send_frame(40'h2D_00_17_05_49);
    n = 0;
    while (sent_cnt < 6 && n < 1000) begin tick(); n++; end
    chk("reset_reach6", int'(sent_cnt >= 6), 1);
    tick();
    rst = 1'b0;
    tick();
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_tx_start", int'(tx_start), 0);
    chk("midrst_tx_data", int'(tx_data), 0);
    chk("midrst_drop", int'(drop_cnt), 0);
    chk("midrst_csum", int'(csum_err), 0);
    rst = 1'b1;
    wait_done(500);
    chk("midrst_no_more", sent_cnt, 6);
    clear_obs();
    send_frame(40'h2D_00_17_05_49);
    wait_done(1000);
    chk_str("after_rst_line", cap, s_ok1);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (!busy && !tx_busy) busy_len = $urandom_range(12, 1);
      frame       = rand_frame();
      frame_valid = ($urandom_range(15, 0) == 0);
      rst         = !($urandom_range(799, 0) == 0);
    end
    tick();
    frame_valid = 1'b0;
    rst = 1'b1;
    wait_done(1000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
